dsp_issue_scheduler: RTL

Issue controller for the tile's DSP48E1 ALU path. It accepts decoded ALU operations (4 source registers, destination, INMODE/OPMODE/ALUMODE), holds any operation whose sources have results still in flight in the DSP pipeline, and issues registered control and operand-select fields to the DSP. It then produces a register-file writeback strobe exactly when P is valid. It sits between the tile instruction decoder and the DSP48E1/register file, replacing same-cycle ALUOUT capture with latency-correct writeback.

---
 rtl/dsp_issue_scheduler_pkg.sv | 31 +++
 rtl/dsp_issue_scheduler_inflight.sv | 42 ++++
 rtl/dsp_issue_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dsp_issue_scheduler_pkg.sv
// Shared tile definitions for the DSP48E1 issue path.
// Holds the DSP control-field widths, register-file geometry, the FSM state
// encoding and the pipeline latency that matches AREG/MREG/PREG = 1.
package dsp_issue_scheduler_pkg;

  localparam int INMODE_W    = 5;
  localparam int OPMODE_W    = 7;
  localparam int ALUMODE_W   = 4;
  localparam int RAW         = 4;
  localparam int NREG        = 16;
  localparam int NSRC        = 4;
  localparam int DSP_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when any of the four packed source indices has a result in flight.
  function automatic logic src_hazard(input logic [NREG-1:0]     pend,
                                      input logic [NSRC*RAW-1:0] src);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend[src[i*RAW +: RAW]]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dsp_issue_scheduler_inflight.sv
// dsp_inflight_tracker: LAT+1 stage shift register of {valid, dst} that
// follows each accepted op through the DSP pipeline.
//   clk, rst (async, active-low), flush  - clock, reset, discard in-flight ops
//   load_valid, load_dst                 - stage 0 load on accept
//   wb_valid, wb_dst                     - last stage (result valid at P)
//   busy                                 - any stage holds a valid op
module dsp_inflight_tracker
  import dsp_issue_scheduler_pkg::*;
#(
  parameter int LAT = DSP_LATENCY,
  parameter int DW  = RAW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load_valid,
  input  logic [DW-1:0] load_dst,
  output logic          wb_valid,
  output logic [DW-1:0] wb_dst,
  output logic          busy
);

  logic [LAT:0]  vld;
  logic [DW-1:0] dst [LAT+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i <= LAT; i++) dst[i] <= '0;
    end else begin
      // Only the valids are cleared on flush; stale dst values are harmless.
      vld    <= flush ? '0 : {vld[LAT-1:0], load_valid};
      dst[0] <= load_dst;
      for (int i = 1; i <= LAT; i++) dst[i] <= dst[i-1];
    end
  end

  assign wb_valid = vld[LAT];
  assign wb_dst   = dst[LAT];
  assign busy     = |vld;

endmodule

// File: rtl/dsp_issue_scheduler.sv
// dsp_issue_scheduler: in-order issue controller for the DSP48E1 ALU path.
// Holds ops whose sources are still in flight (RAW only), issues registered
// control/operand-select fields, and strobes writeback exactly when P is valid.
//   clk, rst (async, active-low), enable (run mode), flush
//   req_*   - decoded op from the instruction decoder, valid/ready handshake
//   issue_* - registered fields to register-file read ports and DSP controls
//   wb_*    - register-file writeback strobe and index
//   busy, stall_count - status
//
// state | meaning
// IDLE  | not in run mode, nothing in flight
// RUN   | accepting ops
// DRAIN | run mode left with ops in flight; let them write back
module dsp_issue_scheduler
  import dsp_issue_scheduler_pkg::*;
#(
  parameter int LATENCY = DSP_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NSRC*RAW-1:0]  req_src,
  input  logic [RAW-1:0]       req_dst,
  input  logic [INMODE_W-1:0]  req_inmode,
  input  logic [OPMODE_W-1:0]  req_opmode,
  input  logic [ALUMODE_W-1:0] req_alumode,
  output logic                 issue_valid,
  output logic [NSRC*RAW-1:0]  issue_src,
  output logic [INMODE_W-1:0]  issue_inmode,
  output logic [OPMODE_W-1:0]  issue_opmode,
  output logic [ALUMODE_W-1:0] issue_alumode,
  output logic                 wb_valid,
  output logic [RAW-1:0]       wb_dst,
  output logic                 busy,
  output logic [15:0]          stall_count
);

  state_t          state, state_nxt;
  logic [NREG-1:0] pending, pending_nxt;
  logic            accept;
  logic            trk_wb_valid;

  dsp_inflight_tracker #(.LAT(LATENCY), .DW(RAW)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load_valid (accept),
    .load_dst   (req_dst),
    .wb_valid   (trk_wb_valid),
    .wb_dst     (wb_dst),
    .busy       (busy)
  );

  // An op reaching P in a flush cycle is being discarded, so no writeback.
  assign wb_valid = trk_wb_valid && !flush;
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = !flush && !src_hazard(pending, req_src);
        if (!enable) state_nxt = busy ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (enable)     state_nxt = ST_RUN;
        else if (!busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clear before set so an accept targeting the register being written
  // back this cycle leaves it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_dst]  = 1'b0;
    if (accept)   pending_nxt[req_dst] = 1'b1;
    if (flush)    pending_nxt          = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid   <= 1'b0;
      issue_src     <= '0;
      issue_inmode  <= '0;
      issue_opmode  <= '0;
      issue_alumode <= '0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        issue_src     <= req_src;
        issue_inmode  <= req_inmode;
        issue_opmode  <= req_opmode;
        issue_alumode <= req_alumode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (state == ST_RUN && req_valid && !req_ready &&
                 stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
